// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM arbiter: slot phase positions, address widths,
// and the screen-start lookup used for hardware-scroll wrap-around.
package ram_arbiter_pkg;

    localparam int          ADDR_W       = 15;
    localparam logic [14:0] TTX_BASE_DEF = 15'h7C00;

    localparam logic [2:0] CPU_ADR_PH = 3'd0;
    localparam logic [2:0] CPU_WE_PH  = 3'd1;
    localparam logic [2:0] CPU_CAP_PH = 3'd2;
    localparam logic [2:0] VID_ADR_PH = 3'd4;
    localparam logic [2:0] VID_CAP_PH = 3'd6;

    typedef enum logic [1:0] {
        MAP_LINEAR = 2'd0,
        MAP_SCROLL = 2'd1,
        MAP_TTX    = 2'd2
    } map_mode_t;

    // Screen start for each {C5,C4} setting; used only when the CRTC runs past 0x8000.
    function automatic logic [14:0] screen_start(input logic [1:0] size);
        logic [14:0] start;
        case (size)
            2'b00:   start = 15'h3000;
            2'b01:   start = 15'h4000;
            2'b10:   start = 15'h6000;
            2'b11:   start = 15'h5800;
            default: start = 15'h3000;
        endcase
        return start;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter and its surroundings (CPU decode, CRTC,
// Video ULA and the RAM macro). master = arbiter side, slave = system side.
interface ram_arbiter_if;

    logic [15:0] cpu_adr;
    logic        cpu_RnW;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_done;
    logic [13:0] cFRAMESTORE;
    logic [2:0]  cROWADDRESS;
    logic [1:0]  scr_size;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        slot_vid;
    logic [14:0] ram_adr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    modport master (
        input  cpu_adr, cpu_RnW, cpu_dout, cFRAMESTORE, cROWADDRESS, scr_size, ram_dout,
        output cpu_din, cpu_done, vid_data, vid_valid, slot_vid, ram_adr, ram_we, ram_din
    );

    modport slave (
        output cpu_adr, cpu_RnW, cpu_dout, cFRAMESTORE, cROWADDRESS, scr_size, ram_dout,
        input  cpu_din, cpu_done, vid_data, vid_valid, slot_vid, ram_adr, ram_we, ram_din
    );

endinterface

// File: rtl/screen_addr_xlate.sv
// Combinational CRTC MA/RA to RAM address translation, covering linear
// graphics, scroll wrap-around past 0x8000 and the teletext window.
module screen_addr_xlate
    import ram_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TTX_BASE = TTX_BASE_DEF
) (
    input  logic [13:0]       ma,
    input  logic [2:0]        ra,
    input  logic [1:0]        scr_size,
    output logic [ADDR_W-1:0] adr
);

    map_mode_t         mode_s;
    logic [ADDR_W-1:0] linear_s;

    // Classify the CRTC address into one of the three mapping regions.
    always_comb begin
        mode_s   = MAP_LINEAR;
        linear_s = {ma[11:0], ra};
        if (ma[13]) begin
            mode_s = MAP_TTX;
        end else if (ma[12]) begin
            mode_s = MAP_SCROLL;
        end else begin
            mode_s = MAP_LINEAR;
        end
    end

    // Form the RAM address; the 15-bit add wraps modulo 32 KiB by construction.
    always_comb begin
        adr = linear_s;
        case (mode_s)
            MAP_LINEAR: adr = linear_s;
            MAP_SCROLL: adr = linear_s + screen_start(scr_size);
            MAP_TTX:    adr = TTX_BASE | {5'b00000, ma[9:0]};
            default:    adr = linear_s;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Splits each 2 MHz period of the 16 MHz clock into a CPU slot (phases 0-3)
// and a video slot (phases 4-7) sharing the single 32 KiB system RAM.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TTX_BASE = TTX_BASE_DEF
) (
    input  logic          clk16MHz,
    input  logic          nRESET,
    ram_arbiter_if.master bus
);

    logic [2:0]        phase_r;
    logic [2:0]        phase_nxt_s;
    logic [ADDR_W-1:0] vid_adr_s;
    logic [ADDR_W-1:0] ram_adr_r;
    logic [7:0]        ram_din_r;
    logic              ram_we_r;
    logic              cpu_wr_s;
    logic [7:0]        cpu_din_r;
    logic              cpu_done_r;
    logic [7:0]        vid_data_r;
    logic              vid_valid_r;

    screen_addr_xlate #(
        .TTX_BASE (TTX_BASE)
    ) u_xlate (
        .ma       (bus.cFRAMESTORE),
        .ra       (bus.cROWADDRESS),
        .scr_size (bus.scr_size),
        .adr      (vid_adr_s)
    );

    // Next phase and write qualification; addresses at or above 0x8000 never write RAM.
    always_comb begin
        phase_nxt_s = phase_r + 3'd1;
        cpu_wr_s    = 1'b0;
        if (!bus.cpu_RnW && !bus.cpu_adr[15]) begin
            cpu_wr_s = 1'b1;
        end else begin
            cpu_wr_s = 1'b0;
        end
    end

    // Free-running slot phase counter.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) begin
            phase_r <= 3'd0;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // RAM address/data/strobe; async reset drops ram_we immediately, even mid-slot.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) begin
            ram_adr_r <= 15'h0000;
            ram_din_r <= 8'h00;
            ram_we_r  <= 1'b0;
        end else begin
            ram_we_r <= (phase_nxt_s == CPU_WE_PH) && cpu_wr_s;
            if (phase_r == CPU_ADR_PH) begin
                ram_adr_r <= bus.cpu_adr[14:0];
                ram_din_r <= bus.cpu_dout;
            end else if (phase_r == VID_ADR_PH) begin
                ram_adr_r <= vid_adr_s;
            end
        end
    end

    // Capture RAM read data for each slot and raise the matching one-cycle pulse.
    always_ff @(posedge clk16MHz or negedge nRESET) begin
        if (!nRESET) begin
            cpu_din_r   <= 8'h00;
            cpu_done_r  <= 1'b0;
            vid_data_r  <= 8'h00;
            vid_valid_r <= 1'b0;
        end else begin
            cpu_done_r  <= (phase_r == CPU_CAP_PH);
            vid_valid_r <= (phase_r == VID_CAP_PH);
            if (phase_r == CPU_CAP_PH) begin
                cpu_din_r <= bus.ram_dout;
            end
            if (phase_r == VID_CAP_PH) begin
                vid_data_r <= bus.ram_dout;
            end
        end
    end

    assign bus.slot_vid  = phase_r[2];
    assign bus.ram_adr   = ram_adr_r;
    assign bus.ram_din   = ram_din_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.cpu_din   = cpu_din_r;
    assign bus.cpu_done  = cpu_done_r;
    assign bus.vid_data  = vid_data_r;
    assign bus.vid_valid = vid_valid_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a write-first synchronous RAM model
// and a standalone check of the address translator.
module tb_ram_arbiter;

    logic clk16MHz;
    logic nRESET;
    logic [2:0] ph;
    int n_checks;
    int n_fail;

    logic [7:0]  mem [0:32767];
    logic        load_en;
    logic [14:0] load_adr;
    logic [7:0]  load_dat;

    logic [13:0] x_ma;
    logic [2:0]  x_ra;
    logic [1:0]  x_size;
    logic [14:0] x_adr;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk16MHz (clk16MHz),
        .nRESET   (nRESET),
        .bus      (bus)
    );

    screen_addr_xlate u_xl (
        .ma       (x_ma),
        .ra       (x_ra),
        .scr_size (x_size),
        .adr      (x_adr)
    );

    initial clk16MHz = 1'b0;
    always #5 clk16MHz = ~clk16MHz;

    // Write-first synchronous RAM with a bench-side preload port.
    always @(posedge clk16MHz) begin
        if (load_en) begin
            mem[load_adr] <= load_dat;
        end else if (bus.ram_we) begin
            mem[bus.ram_adr] <= bus.ram_din;
            bus.ram_dout     <= bus.ram_din;
        end else begin
            bus.ram_dout <= mem[bus.ram_adr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk16MHz);
        #1;
        ph = ph + 3'd1;
    endtask

    task automatic wait_ph(input logic [2:0] p);
        for (int k = 0; k < 8 && ph != p; k++) step();
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk16MHz);
        load_en  = 1'b1;
        load_adr = a;
        load_dat = d;
        @(posedge clk16MHz);
        #1;
        load_en = 1'b0;
    endtask

    typedef struct {
        logic [13:0] ma;
        logic [2:0]  ra;
        logic [1:0]  size;
        logic [14:0] adr;
        logic [7:0]  dat;
    } vid_vec_t;

    vid_vec_t vv [4];
    vid_vec_t xv [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ph       = 3'd0;
        load_en  = 1'b0;
        load_adr = 15'h0000;
        load_dat = 8'h00;
        nRESET   = 1'b0;
        bus.cpu_adr     = 16'h0000;
        bus.cpu_RnW     = 1'b1;
        bus.cpu_dout    = 8'h00;
        bus.cFRAMESTORE = 14'h0000;
        bus.cROWADDRESS = 3'd0;
        bus.scr_size    = 2'b00;
        x_ma   = 14'h0000;
        x_ra   = 3'd0;
        x_size = 2'b00;

        vv[0] = '{14'h0C00, 3'd2, 2'b00, 15'h6002, 8'h5A};
        vv[1] = '{14'h1010, 3'd3, 2'b01, 15'h4083, 8'hC3};
        vv[2] = '{14'h2123, 3'd0, 2'b00, 15'h7D23, 8'h99};
        vv[3] = '{14'h1F00, 3'd0, 2'b00, 15'h2800, 8'h11};
        xv[0] = '{14'h1000, 3'd0, 2'b10, 15'h6000, 8'h00};
        xv[1] = '{14'h1FFF, 3'd7, 2'b11, 15'h57FF, 8'h00};
        xv[2] = '{14'h3FFF, 3'd7, 2'b01, 15'h7FFF, 8'h00};
        xv[3] = '{14'h0FFF, 3'd7, 2'b11, 15'h7FFF, 8'h00};

        // Reset held over the preload clocks.
        preload(15'h1234, 8'hA5);
        preload(15'h1000, 8'h77);
        for (int i = 0; i < 4; i++) preload(vv[i].adr, vv[i].dat);
        check("rst_slot_vid", {31'd0, bus.slot_vid}, 32'd0);
        check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_cpu_din", {24'd0, bus.cpu_din}, 32'd0);
        check("rst_vid_valid", {31'd0, bus.vid_valid}, 32'd0);
        check("rst_cpu_done", {31'd0, bus.cpu_done}, 32'd0);
        check("rst_ram_adr", {17'd0, bus.ram_adr}, 32'd0);

        @(negedge clk16MHz);
        nRESET = 1'b1;
        ph = 3'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("slot_vid_seq", {31'd0, bus.slot_vid}, {31'd0, ph[2]});
        end

        // CPU read, with a mid-slot address change that must be ignored.
        wait_ph(3'd0);
        bus.cpu_adr = 16'h1234;
        bus.cpu_RnW = 1'b1;
        step();
        check("rd_ram_adr", {17'd0, bus.ram_adr}, 32'h1234);
        check("rd_ram_we", {31'd0, bus.ram_we}, 32'd0);
        bus.cpu_adr = 16'h0055;
        step();
        check("rd_adr_held", {17'd0, bus.ram_adr}, 32'h1234);
        check("rd_done_ph2", {31'd0, bus.cpu_done}, 32'd0);
        step();
        check("rd_cpu_done", {31'd0, bus.cpu_done}, 32'd1);
        check("rd_cpu_din", {24'd0, bus.cpu_din}, 32'hA5);
        step();
        check("rd_done_ph4", {31'd0, bus.cpu_done}, 32'd0);

        // CPU write to RAM, read-after-write data on cpu_din.
        wait_ph(3'd0);
        bus.cpu_adr  = 16'h0100;
        bus.cpu_dout = 8'h3C;
        bus.cpu_RnW  = 1'b0;
        step();
        check("wr_ram_we_ph1", {31'd0, bus.ram_we}, 32'd1);
        check("wr_ram_adr", {17'd0, bus.ram_adr}, 32'h0100);
        check("wr_ram_din", {24'd0, bus.ram_din}, 32'h3C);
        bus.cpu_RnW = 1'b1;
        step();
        check("wr_ram_we_ph2", {31'd0, bus.ram_we}, 32'd0);
        step();
        check("wr_cpu_din", {24'd0, bus.cpu_din}, 32'h3C);
        check("wr_mem", {24'd0, mem[15'h0100]}, 32'h3C);

        // Write above 0x8000 must not reach RAM.
        wait_ph(3'd0);
        bus.cpu_adr  = 16'h9000;
        bus.cpu_dout = 8'hEE;
        bus.cpu_RnW  = 1'b0;
        step();
        check("sup_ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("sup_ram_adr", {17'd0, bus.ram_adr}, 32'h1000);
        step();
        step();
        check("sup_cpu_din", {24'd0, bus.cpu_din}, 32'h77);
        check("sup_mem", {24'd0, mem[15'h1000]}, 32'h77);
        bus.cpu_RnW = 1'b1;

        // Video slot: linear, scroll, teletext, wrap past 32 KiB.
        for (int i = 0; i < 4; i++) begin
            wait_ph(3'd4);
            bus.cFRAMESTORE = vv[i].ma;
            bus.cROWADDRESS = vv[i].ra;
            bus.scr_size    = vv[i].size;
            step();
            check("vid_ram_adr", {17'd0, bus.ram_adr}, {17'd0, vv[i].adr});
            check("vid_ram_we", {31'd0, bus.ram_we}, 32'd0);
            step();
            check("vid_valid_ph6", {31'd0, bus.vid_valid}, 32'd0);
            step();
            check("vid_valid_ph7", {31'd0, bus.vid_valid}, 32'd1);
            check("vid_data", {24'd0, bus.vid_data}, {24'd0, vv[i].dat});
            step();
            check("vid_valid_ph0", {31'd0, bus.vid_valid}, 32'd0);
        end

        // Translator standalone: remaining screen sizes and region edges.
        for (int i = 0; i < 4; i++) begin
            x_ma   = xv[i].ma;
            x_ra   = xv[i].ra;
            x_size = xv[i].size;
            #1;
            check("xlate", {17'd0, x_adr}, {17'd0, xv[i].adr});
        end

        // Reset asserted during the write strobe drops it without a clock edge.
        wait_ph(3'd0);
        bus.cpu_adr  = 16'h0200;
        bus.cpu_dout = 8'h42;
        bus.cpu_RnW  = 1'b0;
        step();
        check("mid_we_before", {31'd0, bus.ram_we}, 32'd1);
        #2;
        nRESET = 1'b0;
        #1;
        check("mid_we_async", {31'd0, bus.ram_we}, 32'd0);
        check("mid_ram_adr", {17'd0, bus.ram_adr}, 32'd0);
        bus.cpu_RnW = 1'b1;
        @(posedge clk16MHz);
        @(negedge clk16MHz);
        nRESET = 1'b1;
        ph = 3'd0;
        step();
        check("post_rst_adr", {17'd0, bus.ram_adr}, 32'h0200);
        check("post_rst_we", {31'd0, bus.ram_we}, 32'd0);
        step();
        step();
        check("post_rst_done", {31'd0, bus.cpu_done}, 32'd1);
        check("post_rst_slot3", {31'd0, bus.slot_vid}, 32'd0);
        step();
        check("post_rst_slot4", {31'd0, bus.slot_vid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Time-multiplexes the single 32 KiB system RAM between the 6502 and the video path (CRTC + Video ULA) on the 16 MHz master clock. Every 2 MHz period is split into a CPU slot and a video slot. The block also translates CRTC framestore/row addresses into RAM addresses, including hardware-scroll wrap-around and teletext mapping. It sits between processor bus decode, the CRTC, the Video ULA data input and the RAM macro.

Parameters:
ADDR_W, 15, RAM address width (32 KiB).
TTX_BASE, 15'h7C00, teletext (MA13=1) base address.

Ports:
clk16MHz  in  1  master clock
nRESET  in  1  asynchronous, active-low reset
cpu_adr  in  16  processor address bus
cpu_RnW  in  1  processor read/not-write
cpu_dout  in  8  processor write data
cpu_din  out  8  RAM read data to processor
cpu_done  out  1  one-cycle pulse: CPU slot completed
cFRAMESTORE  in  14  CRTC memory address MA[13:0]
cROWADDRESS  in  3  CRTC raster address RA[2:0]
scr_size  in  2  {C5,C4} from addressable latch
vid_data  out  8  RAM read data to Video ULA
vid_valid  out  1  one-cycle pulse: vid_data updated
slot_vid  out  1  0 = CPU half, 1 = video half (2 MHz phase)
ram_adr  out  15  RAM address
ram_we  out  1  RAM write strobe
ram_din  out  8  RAM write data
ram_dout  in  8  RAM read data (synchronous, 1-cycle latency)

Behaviour:
- Reset (async, nRESET=0): phase=0; all outputs 0; ram_we forced low immediately, including mid-slot.
- phase: 3-bit free-running counter, +1 every clk16MHz, 7 wraps to 0. slot_vid = phase[2].
- CPU slot (phases 0-3):
  - At edge leaving phase 0: ram_adr <= cpu_adr[14:0]; ram_din <= cpu_dout.
  - ram_we = 1 during phase 1 only, and only if cpu_RnW=0 and cpu_adr[15]=0. Writes to >= 0x8000 (ROM/SHEILA) never reach RAM.
  - At edge leaving phase 2: cpu_din <= ram_dout, captured even on a write cycle (read-after-write returns the new data). cpu_done = 1 during phase 3.
  - cpu_adr[15]=1 reads leave cpu_din holding RAM[cpu_adr[14:0]]; external decode ignores it.
- Video slot (phases 4-7):
  - At edge leaving phase 4: ram_adr <= xlate(cFRAMESTORE, cROWADDRESS, scr_size).
  - At edge leaving phase 6: vid_data <= ram_dout; vid_valid = 1 during phase 7.
  - ram_we is always 0 in the video slot, so the video read is never blocked.
- Address translation:
  - MA13=1 (teletext): TTX_BASE | MA[9:0].
  - MA13=0, MA12=0: {MA[11:0],RA[2:0]}.
  - MA13=0, MA12=1 (scroll wrap past 0x8000): ({MA[11:0],RA} + start) mod 2^15.
  - start by scr_size: 00→0x3000, 01→0x4000, 10→0x6000, 11→0x5800.
- Inputs are sampled only at the capture edges listed above; changes between those edges have no effect.

Decomposition:
- Package: slot phase constants (CPU_ADR_PH=0, CPU_WE_PH=1, CPU_CAP_PH=2, VID_ADR_PH=4, VID_CAP_PH=6) and the 4-entry screen-start table.
- Sub-module: screen_addr_xlate, purely combinational MA/RA/scr_size → 15-bit address. It is instantiated once and verified standalone.

Test Plan:
- Reset: hold nRESET=0 across 3 clocks → phase=0, ram_we=0, cpu_din=0, vid_valid=0; release → slot_vid toggles every 4 clocks.
- CPU read: RAM[0x1234]=0xA5, cpu_adr=0x1234, cpu_RnW=1 → ram_adr=0x1234 in phase 1, cpu_din=0xA5 and cpu_done=1 in phase 3.
- CPU write, plus suppression: cpu_adr=0x0100, cpu_dout=0x3C, RnW=0 → ram_we high exactly 1 clock (phase 1), RAM[0x0100]=0x3C. Same with cpu_adr=0x9000 → ram_we stays 0.
- Video no-wrap / wrap: MA=0x0C00, RA=2 → ram_adr=0x6002. MA=0x1010, RA=3, scr_size=01 → ram_adr=0x4083; vid_valid pulses in phase 7 with RAM contents.
- Teletext: MA=0x2123 → ram_adr=0x7D23.
- Reset mid-write: drop nRESET during phase 1 of a write → ram_we falls without a clock edge; phase restarts at 0 after release.
